// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants for the NES sprite (OAM) DMA sequencer.
// Holds the state encoding, the default trigger address and the transfer length.
package oam_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_GET   = 3'd3,
        ST_PUT   = 3'd4
    } state_t;

    localparam logic [15:0] DMA_REG_DEFAULT = 16'h4014;
    localparam int          XFER_LEN        = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// NES $4014 sprite DMA: halts the CPU, copies page $XX00-$XXFF into OAM
// starting at the OAMADDR latched at trigger, with optional odd-cycle alignment.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter logic [15:0] DMA_REG  = DMA_REG_DEFAULT,
    parameter bit          ALIGN_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic [15:0] EA,
    input  logic [7:0]  DIN,
    input  logic        WREQ,
    input  logic [7:0]  OAM_BASE,
    input  logic [7:0]  DATAIN,
    output logic        DMA,
    output logic [15:0] WADDR,
    output logic [7:0]  WDATA,
    output logic [7:0]  OAMA,
    output logic        OAMW,
    output logic        DONE
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] base_q, base_d;
    logic       odd_q, odd_d;
    logic       dma_q, dma_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] oama_q, oama_d;
    logic       oamw_q, oamw_d;
    logic       done_q, done_d;

    logic trigger;
    logic last;

    assign trigger = WREQ && (EA == DMA_REG);
    assign last    = (idx_q == LAST_IDX);

    // NOTE: every flop is written with <= so all registers sample the same pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            page_q  <= '0;
            base_q  <= '0;
            odd_q   <= 1'b0;
            dma_q   <= 1'b0;
            wdata_q <= '0;
            oama_q  <= '0;
            oamw_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            base_q  <= base_d;
            odd_q   <= odd_d;
            dma_q   <= dma_d;
            wdata_q <= wdata_d;
            oama_q  <= oama_d;
            oamw_q  <= oamw_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (CE) begin
            unique case (state_q)
                ST_IDLE:  if (trigger) state_d = ST_HALT;
                ST_HALT:  state_d = (ALIGN_EN && odd_q) ? ST_ALIGN : ST_GET;
                ST_ALIGN: state_d = ST_GET;
                ST_GET:   state_d = ST_PUT;
                ST_PUT:   state_d = last ? ST_IDLE : ST_GET;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: each _d gets a default before any branch, so no path leaves it unassigned (no latches).
    always_comb begin
        odd_d   = odd_q ^ CE;
        idx_d   = idx_q;
        page_d  = page_q;
        base_d  = base_q;
        dma_d   = dma_q;
        wdata_d = wdata_q;
        oama_d  = oama_q;
        oamw_d  = 1'b0;
        done_d  = 1'b0;
        if (CE) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        page_d = DIN;
                        base_d = OAM_BASE;
                        idx_d  = '0;
                        dma_d  = 1'b1;
                    end
                end
                ST_PUT: begin
                    wdata_d = DATAIN;
                    oama_d  = base_q + idx_q;
                    oamw_d  = 1'b1;
                    if (last) begin
                        dma_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // idx only advances at the end of PUT, so the read address is stable across GET and PUT.
    assign WADDR = (state_q == ST_GET || state_q == ST_PUT) ? {page_q, idx_q} : 16'h0000;
    assign DMA   = dma_q;
    assign WDATA = wdata_q;
    assign OAMA  = oama_q;
    assign OAMW  = oamw_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: randomized CE/bus activity against a
// transfer-level model that predicts every output on every cycle.
module tb_oam_dma_ctrl;

    localparam logic [15:0] TRIG = 16'h4014;

    typedef struct {
        int lat;
        int lat_na;
        int nw;
        int nw_na;
        int w0;
        int nd;
    } xfer_res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [15:0] ea = '0;
    logic [7:0]  din = '0;
    logic        wreq = 1'b0;
    logic [7:0]  oam_base = '0;

    logic        dma, oamw, done;
    logic [15:0] waddr;
    logic [7:0]  wdata, oama, datain;
    logic        dma_na, oamw_na, done_na;
    logic [15:0] waddr_na;
    logic [7:0]  wdata_na, oama_na, datain_na;

    logic [7:0] ram [65536];
    assign datain    = ram[waddr];
    assign datain_na = ram[waddr_na];

    oam_dma_ctrl #(.DMA_REG(16'h4014), .ALIGN_EN(1'b1)) u_dut (
        .CLK(clk), .RESET(rst), .CE(ce), .EA(ea), .DIN(din), .WREQ(wreq),
        .OAM_BASE(oam_base), .DATAIN(datain), .DMA(dma), .WADDR(waddr),
        .WDATA(wdata), .OAMA(oama), .OAMW(oamw), .DONE(done)
    );

    oam_dma_ctrl #(.DMA_REG(16'h4014), .ALIGN_EN(1'b0)) u_dut_na (
        .CLK(clk), .RESET(rst), .CE(ce), .EA(ea), .DIN(din), .WREQ(wreq),
        .OAM_BASE(oam_base), .DATAIN(datain_na), .DMA(dma_na), .WADDR(waddr_na),
        .WDATA(wdata_na), .OAMA(oama_na), .OAMW(oamw_na), .DONE(done_na)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer timeline counted in CE edges after the trigger edge:
    // edge 1 ends HALT, edge 2 ends ALIGN when aligning, then byte j is read
    // over a GET edge and written on the following PUT edge.
    function automatic int put_idx(input int nn, input bit al);
        int o;
        int m;
        o = al ? 2 : 1;
        m = nn - o - 1;
        if (m >= 0 && (m % 2) == 1) return m / 2;
        return -1;
    endfunction

    function automatic logic [15:0] exp_waddr(input bit busy, input int n, input bit al,
                                              input logic [7:0] page);
        int o;
        o = al ? 2 : 1;
        if (!busy || n == 0 || n < o) return 16'h0000;
        return {page, 8'((n - o) / 2)};
    endfunction

    bit         m_busy = 1'b0;
    bit         m_parity = 1'b0;
    bit         m_align = 1'b0;
    int         m_n = 0;
    logic [7:0] m_page, m_base, m_oama, m_wdata;
    bit         m_oamw = 1'b0;
    bit         m_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_parity <= 1'b0;
            m_align  <= 1'b0;
            m_n      <= 0;
            m_page   <= '0;
            m_base   <= '0;
            m_oama   <= '0;
            m_wdata  <= '0;
            m_oamw   <= 1'b0;
            m_done   <= 1'b0;
        end else begin
            m_oamw <= 1'b0;
            m_done <= 1'b0;
            if (ce) begin
                m_parity <= ~m_parity;
                if (!m_busy) begin
                    if (wreq && ea == TRIG) begin
                        m_busy <= 1'b1;
                        m_n    <= 0;
                        m_page <= din;
                        m_base <= oam_base;
                    end
                end else begin
                    m_n <= m_n + 1;
                    if (m_n == 0) m_align <= m_parity;
                    if (put_idx(m_n + 1, m_align) >= 0) begin
                        m_oamw  <= 1'b1;
                        m_oama  <= m_base + 8'(put_idx(m_n + 1, m_align));
                        m_wdata <= ram[{m_page, 8'(put_idx(m_n + 1, m_align))}];
                        if (put_idx(m_n + 1, m_align) == 255) begin
                            m_busy <= 1'b0;
                            m_done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    int dut_ces = 0, na_ces = 0, dut_writes = 0, na_writes = 0, dut_dones = 0;
    logic [7:0] log_oama [4096];
    logic [7:0] log_wdata [4096];

    always @(negedge clk) begin
        check("dma", 32'(dma), 32'(m_busy));
        check("oamw", 32'(oamw), 32'(m_oamw));
        check("done", 32'(done), 32'(m_done));
        check("waddr", 32'(waddr), 32'(exp_waddr(m_busy, m_n, m_align, m_page)));
        check("oama", 32'(oama), 32'(m_oama));
        check("wdata", 32'(wdata), 32'(m_wdata));
        if (ce && dma) dut_ces <= dut_ces + 1;
        if (ce && dma_na) na_ces <= na_ces + 1;
        if (oamw) begin
            log_oama[dut_writes % 4096]  <= oama;
            log_wdata[dut_writes % 4096] <= wdata;
            dut_writes <= dut_writes + 1;
        end
        if (oamw_na) na_writes <= na_writes + 1;
        if (done) dut_dones <= dut_dones + 1;
    end

    task automatic drive(input logic c, input logic w, input logic [15:0] a, input logic [7:0] d);
        ce   = c;
        wreq = w;
        ea   = a;
        din  = d;
        @(posedge clk);
        #2;
    endtask

    // want_align selects a trigger edge after which odd=1, so HALT sees odd=1.
    task automatic run_xfer(input logic [7:0] page, input logic [7:0] base, input bit want_align,
                            input int retrig_at, input int reset_at, output xfer_res_t r);
        int s_ces, s_na_ces, s_nwa, s_dn;
        bit timed_out;
        for (int k = 0; k < 3 && m_parity != !want_align; k++) drive(1'b1, 1'b0, 16'h0000, 8'h00);
        s_ces    = dut_ces;
        s_na_ces = na_ces;
        s_nwa    = na_writes;
        s_dn     = dut_dones;
        r.w0     = dut_writes;
        oam_base = base;
        drive(1'b1, 1'b1, TRIG, page);
        timed_out = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!dma && !dma_na) begin
                timed_out = 1'b0;
                break;
            end
            if (reset_at >= 0 && dut_writes - r.w0 == reset_at) begin
                rst = 1'b1;
                #1;
                check("rst_now_dma", 32'(dma), 32'h0);
                check("rst_now_oamw", 32'(oamw), 32'h0);
                check("rst_now_done", 32'(done), 32'h0);
                check("rst_now_waddr", 32'(waddr), 32'h0);
                drive(1'b1, 1'b0, 16'h0000, 8'h00);
                drive(1'b1, 1'b0, 16'h0000, 8'h00);
                rst = 1'b0;
                timed_out = 1'b0;
                break;
            end
            oam_base = 8'($urandom);
            if (retrig_at >= 0 && dut_writes - r.w0 >= retrig_at && dut_writes - r.w0 < retrig_at + 10)
                drive(1'b1, 1'b1, TRIG, 8'h07);
            else
                drive(($urandom % 3) != 0, 1'($urandom), 16'h2000 | 16'($urandom % 4096), 8'($urandom));
        end
        check("xfer_timeout", 32'(timed_out), 32'h0);
        repeat (3) drive(1'b1, 1'b0, 16'h0000, 8'h00);
        r.lat    = dut_ces - s_ces;
        r.lat_na = na_ces - s_na_ces;
        r.nw     = dut_writes - r.w0;
        r.nw_na  = na_writes - s_nwa;
        r.nd     = dut_dones - s_dn;
    endtask

    xfer_res_t r;
    int w_before;

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'hA5;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("reset_dma", 32'(dma), 32'h0);
        check("reset_waddr", 32'(waddr), 32'h0);
        check("reset_wdata", 32'(wdata), 32'h0);
        check("reset_oama", 32'(oama), 32'h0);
        check("reset_oamw", 32'(oamw), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;
        repeat (4) drive(1'b1, 1'b0, 16'h0000, 8'h00);

        // Even start: no alignment cycle.
        run_xfer(8'h02, 8'h00, 1'b0, -1, -1, r);
        check("even_lat", 32'(r.lat), 32'd513);
        check("even_lat_na", 32'(r.lat_na), 32'd513);
        check("even_writes", 32'(r.nw), 32'd256);
        check("even_writes_na", 32'(r.nw_na), 32'd256);
        check("even_dones", 32'(r.nd), 32'd1);
        check("even_first_oama", 32'(log_oama[r.w0 % 4096]), 32'h00);
        check("even_first_wdata", 32'(log_wdata[r.w0 % 4096]), 32'hA5);
        check("even_last_oama", 32'(log_oama[(r.w0 + 255) % 4096]), 32'hFF);
        check("even_last_wdata", 32'(log_wdata[(r.w0 + 255) % 4096]), 32'h5A);

        // Odd start: one extra ALIGN cycle only when alignment is enabled.
        run_xfer(8'h02, 8'h00, 1'b1, -1, -1, r);
        check("odd_lat", 32'(r.lat), 32'd514);
        check("odd_lat_na", 32'(r.lat_na), 32'd513);
        check("odd_writes", 32'(r.nw), 32'd256);
        check("odd_mid_wdata", 32'(log_wdata[(r.w0 + 16) % 4096]), 32'h10 ^ 32'hA5);

        // OAM address wrap with a retrigger attempt (page $07) mid-transfer.
        run_xfer(8'h03, 8'hF0, 1'b0, 50, -1, r);
        check("wrap_lat", 32'(r.lat), 32'd513);
        check("wrap_writes", 32'(r.nw), 32'd256);
        check("wrap_first_oama", 32'(log_oama[r.w0 % 4096]), 32'hF0);
        check("wrap_17th_oama", 32'(log_oama[(r.w0 + 16) % 4096]), 32'h00);
        check("wrap_last_oama", 32'(log_oama[(r.w0 + 255) % 4096]), 32'hEF);
        check("wrap_byte100", 32'(log_wdata[(r.w0 + 100) % 4096]), 32'(ram[16'h0364]));
        check("wrap_last_wdata", 32'(log_wdata[(r.w0 + 255) % 4096]), 32'(ram[16'h03FF]));

        // Non-trigger address, and trigger address without CE.
        w_before = dut_writes;
        drive(1'b1, 1'b1, 16'h4015, 8'h02);
        drive(1'b0, 1'b1, TRIG, 8'h02);
        repeat (4) drive(1'b1, 1'b0, 16'h0000, 8'h00);
        check("notrig_dma", 32'(dma), 32'h0);
        check("notrig_writes", 32'(dut_writes - w_before), 32'd0);

        // Reset after the 100th write, then a fresh full transfer.
        run_xfer(8'h02, 8'h00, 1'b0, -1, 100, r);
        check("rst_mid_writes", 32'(r.nw), 32'd100);
        check("rst_mid_dones", 32'(r.nd), 32'd0);
        check("rst_mid_dma", 32'(dma), 32'h0);
        run_xfer(8'h05, 8'h33, 1'b0, -1, -1, r);
        check("fresh_writes", 32'(r.nw), 32'd256);
        check("fresh_dones", 32'(r.nd), 32'd1);
        check("fresh_first_oama", 32'(log_oama[r.w0 % 4096]), 32'h33);
        check("fresh_last_oama", 32'(log_oama[(r.w0 + 255) % 4096]), 32'h32);
        check("fresh_byte7", 32'(log_wdata[(r.w0 + 7) % 4096]), 32'(ram[16'h0507]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences the NES sprite DMA triggered by a CPU write to $4014.
- Holds the 6502 off the bus through CE, walks 256 bytes of CPU page $XX00-$XXFF, and writes each byte into sprite OAM.
- Sits between the CPU write port (EAWR/DOUT/WREQ), the CPU memory read mux (curaddr/din), and the OAM write port.
- Owns DMA cycle counting, odd-cycle alignment and OAM address wrap.

Parameters:
- DMA_REG, 16'h4014, CPU write address that triggers DMA.
- ALIGN_EN, 1, 1 = insert one extra idle CPU cycle when DMA starts on an odd cycle; 0 = never align.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CE  in  1  one-CLK strobe marking the end of each CPU cycle; all sequencing advances only on CLK edges with CE=1.
- EA  in  16  CPU effective write address.
- DIN  in  8  CPU write data; the page number.
- WREQ  in  1  CPU write request, qualified by CE.
- OAM_BASE  in  8  current PPU OAMADDR, sampled at trigger.
- DATAIN  in  8  CPU memory read data for WADDR, valid by the CE that ends a GET cycle.
- DMA  out  1  busy; CPU halted while 1 (drives CPU CE low and the curaddr mux).
- WADDR  out  16  DMA read address into CPU memory map.
- WDATA  out  8  byte to write into OAM.
- OAMA  out  8  OAM write address.
- OAMW  out  1  OAM write strobe, one CLK wide.
- DONE  out  1  one-CLK pulse after the last OAM write.

Behaviour:
- Reset values: DMA=0, WADDR=0, WDATA=0, OAMA=0, OAMW=0, DONE=0. Internally: state=IDLE, idx=0, page=0, odd=0.
- Parity: odd toggles on every CE edge, including edges during DMA.
- States: IDLE, HALT, ALIGN, GET, PUT. Transitions occur only on CE edges.
- IDLE:
  - On CE with WREQ=1 and EA==DMA_REG: page<=DIN, base<=OAM_BASE, idx<=0, DMA<=1, go to HALT.
  - A matching write without CE is ignored.
- HALT: lasts one CPU cycle. On CE: if ALIGN_EN and odd==1 (pre-toggle value), go to ALIGN; else go to GET.
- ALIGN: lasts one CPU cycle. On CE, go to GET.
- GET:
  - WADDR={page,idx} combinationally for the whole state.
  - On CE: go to PUT. WADDR is held through PUT.
- PUT: on CE:
  - WDATA<=DATAIN.
  - OAMA<=base+idx, 8-bit wrap (base=$F0, idx=$20 gives $10).
  - OAMW<=1 for the following CLK only.
  - If idx==$FF: go to IDLE, DMA<=0, DONE<=1 for one CLK. Else idx<=idx+1 and go to GET.
- Latency from trigger CE to DMA=0 is 513 CE edges (even start) or 514 CE edges (odd start, ALIGN_EN=1).
- Exactly 256 OAMW pulses per transfer, in idx order 0..255.
- WADDR never leaves page: idx increments only after PUT, and idx=$FF does not increment.
- Writes to DMA_REG while DMA=1 are ignored; the page is not relatched.
- WREQ is don't-care while DMA=1, since the CPU is halted.
- DONE and the new IDLE state share an edge. A trigger cannot arrive in that same CE because the CPU was halted.
- RESET mid-transfer: immediately returns to IDLE with all outputs at reset values. No further OAMW; the partial OAM contents are kept.
- OAM_BASE changes during DMA have no effect (base is latched at trigger).

Decomposition:
- Shared package holds:
  - state encoding constants: ST_IDLE=0, ST_HALT=1, ST_ALIGN=2, ST_GET=3, ST_PUT=4;
  - DMA_REG default;
  - the transfer length constant 256.
- Single module, no sub-module. The parity toggle and the 8-bit idx counter are inline.

Test Plan:
- Even-start transfer:
  - Stimulus: odd=0 at trigger, write $4014<=$02, OAM_BASE=$00, RAM $0200+i=i^$A5.
  - Required: DMA high 513 CEs; 256 OAMW pulses with OAMA=i, WDATA=i^$A5; DONE one pulse; DMA=0 after.
- Odd-start alignment:
  - Stimulus: same transfer, triggered when odd=1.
  - Required: first GET delayed one CE; DMA high 514 CEs.
  - Repeat with ALIGN_EN=0: 513 CEs.
- OAM address wrap:
  - Stimulus: OAM_BASE=$F0, page $03.
  - Required: first write OAMA=$F0, 17th write OAMA=$00, last write OAMA=$EF; WADDR stays in $0300-$03FF.
- Non-trigger and unqualified writes:
  - Stimulus: write $4015 with CE, and $4014 with CE=0.
  - Required: DMA stays 0; no OAMW.
- Reset mid-transfer:
  - Stimulus: assert RESET after the 100th OAMW.
  - Required: DMA, OAMW, DONE and WADDR drop to 0 within the same CLK; no further OAMW; a fresh $4014 write afterwards runs a full 256-byte transfer.
- Retrigger during busy:
  - Stimulus: force a WREQ to $4014 with DIN=$07 mid-DMA.
  - Required: page unchanged; transfer completes from the original page.
